// File: rtl/c3aibadapt_tx_csr.sv
// c3aibadapt_tx_csr: AVMM slave register bank for the TX channel.
// Holds twelve configuration bytes driven as a flat bus, registered TX status,
// a sticky write-1-to-clear event register and a control byte with a write-lock.
module c3aibadapt_tx_csr #(
    parameter logic [95:0] CFG_RESET = 96'h0
) (
    input  logic        avmm_clk,
    input  logic        avmm_rst_n,
    input  logic [3:0]  avmm_address,
    input  logic        avmm_write,
    input  logic        avmm_read,
    input  logic [7:0]  avmm_writedata,
    output logic [7:0]  avmm_readdata,
    output logic        avmm_readdatavalid,
    output logic        avmm_waitrequest,
    input  logic [15:0] tx_status_in,
    input  logic [7:0]  tx_event_in,
    output logic [95:0] csr_tx_cfg,
    output logic        csr_cfg_update
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RD_SAMPLE = 2'd1,
        ST_RD_ACK    = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_cfg [12];
    logic [7:0]  r_ctrl;
    logic [7:0]  r_event;
    logic [15:0] r_status;
    logic [7:0]  r_readdata;
    logic [3:0]  r_rd_addr;
    logic        r_cfg_update;

    logic        w_wr_acc;
    logic        w_rd_acc;
    logic        w_cfg_wr;
    logic        w_wait;
    logic [7:0]  w_rd_mux;
    logic [7:0]  w_event_clr;

    // A write is only taken in IDLE; it beats a simultaneous read.
    assign w_wr_acc    = (r_state == ST_IDLE) && avmm_write;
    assign w_rd_acc    = (r_state == ST_IDLE) && avmm_read && !avmm_write;
    assign w_cfg_wr    = w_wr_acc && (avmm_address < 4'd12) && !r_ctrl[0];
    assign w_event_clr = (w_wr_acc && avmm_address == 4'hE) ? avmm_writedata : 8'h00;

    // Handshake state register.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) r_state <= ST_IDLE;
        else             r_state <= w_state_next;
    end

    // Next-state and stall decode: reads take three cycles, writes complete at once.
    always_comb begin
        w_state_next = r_state;
        w_wait       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rd_acc) begin
                    w_wait       = 1'b1;
                    w_state_next = ST_RD_SAMPLE;
                end
            end
            ST_RD_SAMPLE: begin
                w_wait       = 1'b1;
                w_state_next = ST_RD_ACK;
            end
            ST_RD_ACK: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // One register per configuration byte, each resetting to its slice of CFG_RESET.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_cfg
            always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
                if (!avmm_rst_n)
                    r_cfg[gi] <= CFG_RESET[8*gi +: 8];
                else if (w_cfg_wr && avmm_address == 4'(gi))
                    r_cfg[gi] <= avmm_writedata;
            end
            assign csr_tx_cfg[8*gi +: 8] = r_cfg[gi];
        end
    endgenerate

    // Control byte, status capture, sticky events (a new event beats a clear) and update strobe.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            r_ctrl       <= 8'h00;
            r_status     <= 16'h0000;
            r_event      <= 8'h00;
            r_cfg_update <= 1'b0;
        end else begin
            if (w_wr_acc && avmm_address == 4'hF) r_ctrl <= avmm_writedata;
            r_status     <= tx_status_in;
            r_event      <= (r_event & ~w_event_clr) | tx_event_in;
            r_cfg_update <= w_cfg_wr;
        end
    end

    // Read-data mux over the address held since the read was accepted.
    always_comb begin
        w_rd_mux = 8'h00;
        case (r_rd_addr)
            4'hC:    w_rd_mux = r_status[7:0];
            4'hD:    w_rd_mux = r_status[15:8];
            4'hE:    w_rd_mux = r_event;
            4'hF:    w_rd_mux = r_ctrl;
            default: w_rd_mux = r_cfg[r_rd_addr];
        endcase
    end

    // Latch the read address on accept and capture read data during RD_SAMPLE.
    always_ff @(posedge avmm_clk or negedge avmm_rst_n) begin
        if (!avmm_rst_n) begin
            r_rd_addr  <= 4'h0;
            r_readdata <= 8'h00;
        end else begin
            if (w_rd_acc)                  r_rd_addr  <= avmm_address;
            if (r_state == ST_RD_SAMPLE)   r_readdata <= w_rd_mux;
        end
    end

    assign avmm_readdata      = r_readdata;
    assign avmm_readdatavalid = (r_state == ST_RD_ACK);
    assign avmm_waitrequest   = w_wait;
    assign csr_cfg_update     = r_cfg_update;

endmodule

// File: tb/tb_c3aibadapt_tx_csr.sv
// Testbench for c3aibadapt_tx_csr: directed AVMM transactions, a transaction-level
// register model checked every cycle, and literal expectations at key points.
module tb_c3aibadapt_tx_csr;

    localparam logic [95:0] CFG_R = 96'h0B0A_0908_0706_0504_0302_01A5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  avmm_address = 4'h0;
    logic        avmm_write = 1'b0;
    logic        avmm_read = 1'b0;
    logic [7:0]  avmm_writedata = 8'h00;
    logic [7:0]  avmm_readdata;
    logic        avmm_readdatavalid;
    logic        avmm_waitrequest;
    logic [15:0] tx_status_in = 16'h0000;
    logic [7:0]  tx_event_in = 8'h00;
    logic [95:0] csr_tx_cfg;
    logic        csr_cfg_update;

    c3aibadapt_tx_csr #(.CFG_RESET(CFG_R)) dut (
        .avmm_clk          (clk),
        .avmm_rst_n        (rst_n),
        .avmm_address      (avmm_address),
        .avmm_write        (avmm_write),
        .avmm_read         (avmm_read),
        .avmm_writedata    (avmm_writedata),
        .avmm_readdata     (avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .avmm_waitrequest  (avmm_waitrequest),
        .tx_status_in      (tx_status_in),
        .tx_event_in       (tx_event_in),
        .csr_tx_cfg        (csr_tx_cfg),
        .csr_cfg_update    (csr_cfg_update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [7:0]  m_cfg [12];
    logic [7:0]  m_ctrl;
    logic [7:0]  m_event;
    logic [15:0] m_status;
    logic [7:0]  m_rdata;
    logic [3:0]  m_rd_addr;
    logic        m_upd;
    logic        m_accw;
    int          m_rd_left;   // cycles remaining in an outstanding read (2 = sampling, 1 = acknowledging)

    function automatic logic [7:0] m_reg(input logic [3:0] a);
        if (a < 4'd12)      return m_cfg[a];
        else if (a == 4'hC) return m_status[7:0];
        else if (a == 4'hD) return m_status[15:8];
        else if (a == 4'hE) return m_event;
        else                return m_ctrl;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 12; n++) m_cfg[n] = CFG_R[8*n +: 8];
            m_ctrl = 8'h00; m_event = 8'h00; m_status = 16'h0000;
            m_rdata = 8'h00; m_rd_addr = 4'h0; m_upd = 1'b0; m_rd_left = 0;
        end else begin
            if (m_rd_left == 2) m_rdata = m_reg(m_rd_addr);
            m_accw = (m_rd_left == 0) && avmm_write;
            if (m_rd_left > 0) m_rd_left--;
            else if (avmm_read && !avmm_write) begin
                m_rd_left = 2;
                m_rd_addr = avmm_address;
            end
            m_upd = 1'b0;
            if (m_accw && avmm_address == 4'hE) m_event = m_event & ~avmm_writedata;
            m_event = m_event | tx_event_in;
            if (m_accw && avmm_address < 4'd12 && !m_ctrl[0]) begin
                m_cfg[avmm_address] = avmm_writedata;
                m_upd = 1'b1;
            end
            if (m_accw && avmm_address == 4'hF) m_ctrl = avmm_writedata;
            m_status = tx_status_in;
        end
    end

    // Compare DUT against model away from the active edge, every cycle.
    always @(negedge clk) begin
        logic [95:0] exp_cfg;
        for (int n = 0; n < 12; n++) exp_cfg[8*n +: 8] = m_cfg[n];
        check("cfg_bus", csr_tx_cfg, exp_cfg);
        check("cfg_update", 96'(csr_cfg_update), 96'(m_upd));
        check("readdatavalid", 96'(avmm_readdatavalid), 96'(m_rd_left == 1));
        if (m_rd_left == 0)
            check("waitrequest", 96'(avmm_waitrequest), 96'(avmm_read && !avmm_write));
        else
            check("waitrequest", 96'(avmm_waitrequest), 96'(m_rd_left == 2));
        if (m_rd_left == 1) check("readdata", 96'(avmm_readdata), 96'(m_rdata));
        if (!rst_n) check("readdata_in_reset", 96'(avmm_readdata), 96'h0);
    end

    // ---------------- stimulus tasks (entered at posedge+1) ----------------
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        avmm_address = a; avmm_writedata = d; avmm_write = 1'b1;
        @(posedge clk); #1;
        avmm_write = 1'b0;
        $display("WR addr=%0h data=%02h cfg=%024h", a, d, csr_tx_cfg);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        bit got = 0;
        d = 8'h00;
        avmm_address = a; avmm_read = 1'b1;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            if (avmm_readdatavalid) begin
                got = 1;
                d = avmm_readdata;
                check("rd_latency", 96'(c), 96'd2);
            end else if (c < 2) begin
                check("rd_wait_hold", 96'(avmm_waitrequest), 96'd1);
            end
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL rd_timeout: no readdatavalid for addr %0h", a);
        end
        @(posedge clk); #1;
        avmm_read = 1'b0;
        $display("RD addr=%0h data=%02h", a, d);
    endtask

    logic [7:0] d;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_cfg", csr_tx_cfg, CFG_R);
        check("reset_rdv", 96'(avmm_readdatavalid), 96'h0);
        check("reset_upd", 96'(csr_cfg_update), 96'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rd(4'h0, d);  check("rd_cfg0_reset", 96'(d), 96'hA5);

        wr(4'h3, 8'h5C);
        check("cfg3_written", 96'(csr_tx_cfg[31:24]), 96'h5C);
        check("upd_pulse", 96'(csr_cfg_update), 96'h1);
        @(posedge clk); #1;
        check("upd_one_cycle", 96'(csr_cfg_update), 96'h0);
        rd(4'h3, d);  check("rd_cfg3", 96'(d), 96'h5C);

        wr(4'hF, 8'h01);
        wr(4'h0, 8'hFF);
        check("locked_cfg0", 96'(csr_tx_cfg[7:0]), 96'hA5);
        check("locked_no_upd", 96'(csr_cfg_update), 96'h0);
        wr(4'hF, 8'h00);
        wr(4'h0, 8'hFF);
        check("unlocked_cfg0", 96'(csr_tx_cfg[7:0]), 96'hFF);

        wr(4'h4, 8'h11); wr(4'h5, 8'h22); wr(4'hB, 8'h33);
        check("b2b_cfg", 96'(csr_tx_cfg[95:88]), 96'h33);

        tx_status_in = 16'hBEEF;
        @(posedge clk); #1;
        rd(4'hC, d);  check("rd_status_lo", 96'(d), 96'hEF);
        rd(4'hD, d);  check("rd_status_hi", 96'(d), 96'hBE);
        tx_status_in = 16'h1234;
        rd(4'hC, d);  check("rd_status_delay", 96'(d), 96'h34);

        tx_event_in = 8'h81;
        @(posedge clk); #1;
        tx_event_in = 8'h00;
        rd(4'hE, d);  check("event_set", 96'(d), 96'h81);
        avmm_address = 4'hE; avmm_writedata = 8'h01; avmm_write = 1'b1; tx_event_in = 8'h01;
        @(posedge clk); #1;
        avmm_write = 1'b0; tx_event_in = 8'h00;
        rd(4'hE, d);  check("event_set_wins", 96'(d), 96'h81);
        wr(4'hE, 8'h81);
        rd(4'hE, d);  check("event_cleared", 96'(d), 96'h00);

        avmm_address = 4'h2; avmm_writedata = 8'h33; avmm_write = 1'b1; avmm_read = 1'b1;
        @(posedge clk); #1;
        avmm_write = 1'b0; avmm_read = 1'b0;
        check("rw_write_taken", 96'(csr_tx_cfg[23:16]), 96'h33);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rw_no_rdv", 96'(avmm_readdatavalid), 96'h0);
        end
        @(posedge clk); #1;

        rd(4'h3, d);  check("rd_before_reset", 96'(d), 96'h5C);
        avmm_address = 4'h0; avmm_read = 1'b1;
        @(posedge clk); #1;
        check("mid_read_wait", 96'(avmm_waitrequest), 96'h1);
        rst_n = 1'b0; avmm_read = 1'b0;
        #1;
        check("rst_rdv", 96'(avmm_readdatavalid), 96'h0);
        check("rst_rdata", 96'(avmm_readdata), 96'h00);
        check("rst_cfg", csr_tx_cfg, CFG_R);
        check("rst_wait", 96'(avmm_waitrequest), 96'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_no_rdv", 96'(avmm_readdatavalid), 96'h0);
        end
        @(posedge clk); #1;
        rd(4'h0, d);  check("rd_cfg0_after_rst", 96'(d), 96'hA5);
        rd(4'hF, d);  check("rd_ctrl_after_rst", 96'(d), 96'h00);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
